// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
//   Shared definitions for the I2C target front end that feeds the PID gain
//   register file.
//   - state_e    : byte-engine FSM phases
//   - fsm_dbg_t  : FSM phase plus the ACK-phase flag, as exposed for debug
//   - K_*_ADDR   : register-file addresses of the K_p / K_i / K_d gains
//   - I2C_RW_WRITE : value of the R/W bit that selects a write transfer
//   - addr_match : compares the address byte against the 7-bit target address
// ---------------------------------------------------------------------------
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_REG   = 3'd2,
      ST_WDATA = 3'd3,
      ST_RDATA = 3'd4,
      ST_RACK  = 3'd5
   } state_e;

   // ack_phase is set while the 9th (ACK) clock of a byte is in progress.
   typedef struct packed {
      state_e state;
      logic   ack_phase;
   } fsm_dbg_t;

   localparam logic [7:0] K_P_ADDR = 8'h20;
   localparam logic [7:0] K_I_ADDR = 8'h21;
   localparam logic [7:0] K_D_ADDR = 8'h22;

   localparam logic I2C_RW_WRITE = 1'b0;

   function automatic logic addr_match(input logic [7:0] addr_byte,
                                       input logic [6:0] dev_addr);
      return (addr_byte[7:1] == dev_addr);
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
//   Brings the asynchronous SCL/SDA pad inputs into the clk domain and
//   derives single-clk event pulses from them.
//   Ports:
//     clk, rst_n         : system clock, asynchronous active-low reset
//     scl_in, sda_in     : raw pad inputs
//     scl_rise, scl_fall : one-clk pulses on synchronised SCL edges
//     start_det          : SDA fell while SCL was high (START / repeated START)
//     stop_det           : SDA rose while SCL was high (STOP)
//     sda_val            : synchronised SDA, aligned with the pulses above
//   All outputs are registered, so an event appears SYNC_STAGES+1 clk after
//   the pad change.
// ---------------------------------------------------------------------------
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_val
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_prev;
   logic                   sda_prev;
   logic                   scl_s;
   logic                   sda_s;
   logic                   start_c;
   logic                   stop_c;

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   // START/STOP need SCL high on both samples, so they can never coincide
   // with an SCL edge; the masking below keeps that priority explicit.
   assign start_c = scl_s & scl_prev & sda_prev & ~sda_s;
   assign stop_c  = scl_s & scl_prev & ~sda_prev & sda_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // Lines reset to the idle-high bus level so release of reset
         // cannot fabricate a START or an SCL edge.
         scl_sync  <= '1;
         sda_sync  <= '1;
         scl_prev  <= 1'b1;
         sda_prev  <= 1'b1;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         sda_val   <= 1'b1;
      end else begin
         scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_prev  <= scl_s;
         sda_prev  <= sda_s;
         scl_rise  <= scl_s & ~scl_prev & ~(start_c | stop_c);
         scl_fall  <= ~scl_s & scl_prev & ~(start_c | stop_c);
         start_det <= start_c;
         stop_det  <= stop_c;
         sda_val   <= sda_s;
      end
   end

endmodule

// File: rtl/i2c_target_frontend.sv
// ---------------------------------------------------------------------------
// i2c_target_frontend
//   I2C target byte engine in front of the PID gain register file.
//   A write transfer sets the register pointer and then writes data bytes at
//   an auto-incrementing pointer; a read transfer returns read_value for the
//   current pointer, auto-incrementing on each controller ACK.
//   Ports:
//     clk, rst_n      : system clock (>= 16x SCL), async active-low reset
//     ena             : 0 holds the engine idle with SDA released
//     scl_in, sda_in  : raw bus inputs
//     sda_oe          : 1 pulls SDA low (open drain)
//     reg_addr        : register pointer into the register file
//     update_value    : write data (data byte bits [5:0])
//     read_or_write   : one-clk write strobe when a data byte commits
//     read_value      : register file read data at reg_addr
//     busy            : address-matched transfer in progress
//     dbg_state       : {FSM state, ACK-phase flag}
//   Handshake: read_or_write is a single-clk valid with no ready; the
//   register file must capture update_value at reg_addr on that clk.
// ---------------------------------------------------------------------------
module i2c_target_frontend
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h48,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [5:0] update_value,
   output logic       read_or_write,
   input  logic [5:0] read_value,
   output logic       busy,
   output logic [3:0] dbg_state
);

   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;
   logic sda_val;

   i2c_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_val   (sda_val)
   );

   // Registered state
   state_e     state_q,    state_n;
   logic       ack_q,      ack_n;
   logic [3:0] bit_cnt_q,  bit_cnt_n;
   logic [7:0] shift_q,    shift_n;
   logic       rw_q,       rw_n;
   logic [7:0] reg_addr_q, reg_addr_n;
   logic [5:0] upd_q,      upd_n;
   logic       sda_oe_q,   sda_oe_n;
   logic       busy_q,     busy_n;
   logic       strobe_q,   strobe_n;

   logic [7:0] rx_byte;
   logic [7:0] load_byte;
   fsm_dbg_t   dbg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ack_q      <= 1'b0;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         rw_q       <= 1'b0;
         reg_addr_q <= 8'h00;
         upd_q      <= 6'h00;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         strobe_q   <= 1'b0;
      end else begin
         state_q    <= state_n;
         ack_q      <= ack_n;
         bit_cnt_q  <= bit_cnt_n;
         shift_q    <= shift_n;
         rw_q       <= rw_n;
         reg_addr_q <= reg_addr_n;
         upd_q      <= upd_n;
         sda_oe_q   <= sda_oe_n;
         busy_q     <= busy_n;
         strobe_q   <= strobe_n;
      end
   end

   always_comb begin
      state_n    = state_q;
      ack_n      = ack_q;
      bit_cnt_n  = bit_cnt_q;
      shift_n    = shift_q;
      rw_n       = rw_q;
      reg_addr_n = reg_addr_q;
      upd_n      = upd_q;
      sda_oe_n   = sda_oe_q;
      busy_n     = busy_q;
      strobe_n   = 1'b0;
      // Byte as it stands once the bit sampled on this SCL rise is shifted in.
      rx_byte    = {shift_q[6:0], sda_val};
      load_byte  = {2'b00, read_value};

      if (!ena) begin
         state_n   = ST_IDLE;
         ack_n     = 1'b0;
         bit_cnt_n = 4'd0;
         sda_oe_n  = 1'b0;
         busy_n    = 1'b0;
      end else if (start_det) begin
         // START and repeated START both restart address reception; the
         // pointer is kept so a pointer write can be followed by Sr + read.
         state_n   = ST_ADDR;
         ack_n     = 1'b0;
         bit_cnt_n = 4'd0;
         sda_oe_n  = 1'b0;
      end else if (stop_det) begin
         state_n   = ST_IDLE;
         ack_n     = 1'b0;
         bit_cnt_n = 4'd0;
         sda_oe_n  = 1'b0;
         busy_n    = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_REG, ST_WDATA: begin
               if (scl_rise && !ack_q && (bit_cnt_q < 4'd8)) begin
                  shift_n   = rx_byte;
                  bit_cnt_n = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     case (state_q)
                        ST_ADDR: begin
                           if (addr_match(rx_byte, DEV_ADDR)) begin
                              busy_n = 1'b1;
                              rw_n   = rx_byte[0];
                           end else begin
                              // Not for us: never drive ACK, go quiet.
                              state_n   = ST_IDLE;
                              bit_cnt_n = 4'd0;
                              busy_n    = 1'b0;
                           end
                        end
                        ST_REG: begin
                           reg_addr_n = rx_byte;
                        end
                        default: begin
                           upd_n    = rx_byte[5:0];
                           strobe_n = 1'b1;
                        end
                     endcase
                  end
               end else if (scl_fall) begin
                  if (ack_q) begin
                     // End of our ACK clock: release SDA and move on.
                     ack_n     = 1'b0;
                     bit_cnt_n = 4'd0;
                     sda_oe_n  = 1'b0;
                     case (state_q)
                        ST_ADDR: begin
                           if (rw_q == I2C_RW_WRITE) begin
                              state_n = ST_REG;
                           end else begin
                              // First read bit must be on the bus at this fall.
                              shift_n  = load_byte;
                              sda_oe_n = ~load_byte[7];
                              state_n  = ST_RDATA;
                           end
                        end
                        ST_REG: begin
                           state_n = ST_WDATA;
                        end
                        default: begin
                           reg_addr_n = reg_addr_q + 8'd1;
                        end
                     endcase
                  end else if (bit_cnt_q == 4'd8) begin
                     ack_n    = 1'b1;
                     sda_oe_n = 1'b1;
                  end
               end
            end

            ST_RDATA: begin
               if (scl_rise && (bit_cnt_q < 4'd8)) begin
                  bit_cnt_n = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     // Hand SDA to the controller for its ACK/NACK.
                     sda_oe_n  = 1'b0;
                     bit_cnt_n = 4'd0;
                     state_n   = ST_RACK;
                  end else begin
                     shift_n  = {shift_q[6:0], 1'b0};
                     sda_oe_n = ~shift_q[6];
                  end
               end
            end

            ST_RACK: begin
               if (scl_rise && !ack_q) begin
                  if (sda_val) begin
                     // NACK ends the read; wait for STOP or Sr.
                     state_n = ST_IDLE;
                  end else begin
                     ack_n      = 1'b1;
                     reg_addr_n = reg_addr_q + 8'd1;
                  end
               end else if (scl_fall && ack_q) begin
                  // read_value already reflects the incremented pointer.
                  ack_n     = 1'b0;
                  shift_n   = load_byte;
                  sda_oe_n  = ~load_byte[7];
                  bit_cnt_n = 4'd0;
                  state_n   = ST_RDATA;
               end
            end

            ST_IDLE: begin
               ack_n     = 1'b0;
               bit_cnt_n = 4'd0;
               sda_oe_n  = 1'b0;
            end

            default: begin
               state_n   = ST_IDLE;
               ack_n     = 1'b0;
               bit_cnt_n = 4'd0;
               sda_oe_n  = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      dbg.state     = state_q;
      dbg.ack_phase = ack_q;
   end

   assign sda_oe        = sda_oe_q;
   assign reg_addr      = reg_addr_q;
   assign update_value  = upd_q;
   assign read_or_write = strobe_q;
   assign busy          = busy_q;
   assign dbg_state     = dbg;

endmodule

// File: tb/tb_i2c_target_frontend.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_frontend
//   Open-drain I2C bus (pull-ups) driven by a bit-level controller model at
//   SCL = clk/32, with a three-entry gain register file on the DUT outputs.
//   Expected ACKs, read bytes and write strobes come from a transaction-level
//   model of the target (pointer + register array) and are queued; monitors
//   pop and compare as the bus/DUT produces them.
// ---------------------------------------------------------------------------
module tb_i2c_target_frontend;
   import i2c_pkg::*;

   localparam logic [6:0] TB_DEV = 7'h48;

   // Clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic ena   = 1'b0;
   always #5 clk = ~clk;

   // Bus: controller drives SCL; SDA is wired-AND of controller and target.
   logic scl_drv  = 1'b1;
   logic sda_ctrl = 1'b1;
   logic sda_line;
   logic scl_line;

   logic       sda_oe;
   logic [7:0] reg_addr;
   logic [5:0] update_value;
   logic       read_or_write;
   logic [5:0] read_value;
   logic       busy;
   logic [3:0] dbg_state;

   assign sda_line = sda_ctrl & ~sda_oe;
   assign scl_line = scl_drv;

   i2c_target_frontend #(
      .DEV_ADDR    (TB_DEV),
      .SYNC_STAGES (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ena           (ena),
      .scl_in        (scl_line),
      .sda_in        (sda_line),
      .sda_oe        (sda_oe),
      .reg_addr      (reg_addr),
      .update_value  (update_value),
      .read_or_write (read_or_write),
      .read_value    (read_value),
      .busy          (busy),
      .dbg_state     (dbg_state)
   );

   // Gain register file
   logic [5:0] rf [3] = '{6'h00, 6'h00, 6'h00};
   always @(posedge clk) begin
      if (read_or_write) begin
         if (reg_addr == K_P_ADDR) rf[0] <= update_value;
         if (reg_addr == K_I_ADDR) rf[1] <= update_value;
         if (reg_addr == K_D_ADDR) rf[2] <= update_value;
      end
   end
   always_comb begin
      read_value = 6'h00;
      if (reg_addr == K_P_ADDR) read_value = rf[0];
      if (reg_addr == K_I_ADDR) read_value = rf[1];
      if (reg_addr == K_D_ADDR) read_value = rf[2];
   end

   // Scoreboard state
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  exp_q[$];
   string       name_q[$];
   logic [7:0]  act_q[$];
   logic [13:0] exp_stb_q[$];
   logic [7:0]  dq[$];

   // Reference model: pointer and the three gain registers
   logic [7:0] m_ptr = 8'h00;
   logic [5:0] m_rf [3] = '{6'h00, 6'h00, 6'h00};

   function automatic logic [5:0] m_read(input logic [7:0] a);
      if (a >= 8'h20 && a <= 8'h22) return m_rf[int'(a) - 32];
      return 6'h00;
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   // Bus monitor: compares what the controller saw against the model.
   initial begin
      logic [7:0] a;
      logic [7:0] e;
      string      nm;
      forever begin
         @(negedge clk);
         while (act_q.size() > 0) begin
            a = act_q.pop_front();
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL bus_unexpected: got 0x%0h, want nothing", a);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               if (a !== e) begin
                  n_fail++;
                  $display("FAIL %s: got 0x%0h, want 0x%0h", nm, a, e);
               end
            end
         end
      end
   end

   // Strobe monitor: every write strobe must match the next expected write.
   initial begin
      logic [13:0] e;
      forever begin
         @(negedge clk);
         if (read_or_write !== 1'b0) begin
            n_tests++;
            if (exp_stb_q.size() == 0) begin
               n_fail++;
               $display("FAIL strobe_unexpected: got addr 0x%0h val 0x%0h, want none",
                        reg_addr, update_value);
            end else begin
               e = exp_stb_q.pop_front();
               if ({reg_addr, update_value} !== e) begin
                  n_fail++;
                  $display("FAIL strobe: got addr 0x%0h val 0x%0h, want addr 0x%0h val 0x%0h",
                           reg_addr, update_value, e[13:6], e[5:0]);
               end
            end
         end
      end
   end

   // Watchdog
   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

   // Driver tasks
   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic bus_start();
      sda_ctrl = 1'b1; scl_drv = 1'b1; clk_wait(8);
      sda_ctrl = 1'b0; clk_wait(16);
      scl_drv  = 1'b0; clk_wait(8);
   endtask

   task automatic bus_rstart();
      sda_ctrl = 1'b1; clk_wait(8);
      scl_drv  = 1'b1; clk_wait(16);
      sda_ctrl = 1'b0; clk_wait(16);
      scl_drv  = 1'b0; clk_wait(8);
   endtask

   task automatic bus_stop();
      sda_ctrl = 1'b0; clk_wait(8);
      scl_drv  = 1'b1; clk_wait(16);
      sda_ctrl = 1'b1; clk_wait(16);
   endtask

   task automatic bus_bit(input logic b, output logic seen);
      sda_ctrl = b; clk_wait(8);
      scl_drv  = 1'b1; clk_wait(8);
      @(negedge clk) seen = sda_line;
      clk_wait(8);
      scl_drv  = 1'b0; clk_wait(8);
   endtask

   task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string nm);
      logic s;
      exp_q.push_back({7'd0, exp_ack});
      name_q.push_back(nm);
      for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
      bus_bit(1'b1, s);
      act_q.push_back({7'd0, s});
   endtask

   task automatic rd_byte(input logic [7:0] exp_b, input logic ack, input string nm);
      logic       s;
      logic [7:0] v;
      exp_q.push_back(exp_b);
      name_q.push_back(nm);
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s);
         v[i] = s;
      end
      bus_bit(ack, s);
      act_q.push_back(v);
   endtask

   // Write transfer body: address byte, then dq (pointer then data bytes).
   task automatic wr_body(input logic [7:0] addr_byte);
      logic match;
      match = (addr_byte[7:1] == TB_DEV) && (addr_byte[0] == I2C_RW_WRITE);
      wr_byte(addr_byte, !match, "addr_ack");
      if (match) begin
         for (int i = 0; i < dq.size(); i++) begin
            if (i == 0) begin
               m_ptr = dq[i];
            end else begin
               exp_stb_q.push_back({m_ptr, dq[i][5:0]});
               if (m_ptr >= 8'h20 && m_ptr <= 8'h22) m_rf[int'(m_ptr) - 32] = dq[i][5:0];
               m_ptr = m_ptr + 8'd1;
            end
            wr_byte(dq[i], 1'b0, (i == 0) ? "ptr_ack" : "data_ack");
         end
      end
   endtask

   // Read transfer body: n bytes, last one NACKed.
   task automatic rd_body(input int n);
      wr_byte({TB_DEV, 1'b1}, 1'b0, "raddr_ack");
      for (int i = 0; i < n; i++) begin
         rd_byte({2'b00, m_read(m_ptr)}, (i == n - 1), "rdata");
         if (i != n - 1) m_ptr = m_ptr + 8'd1;
      end
   endtask

   task automatic end_txn();
      bus_stop();
      clk_wait(4);
      @(negedge clk);
      check("busy_after_stop", {15'd0, busy}, 16'd0);
      check("ptr_after_stop", {8'd0, reg_addr}, {8'd0, m_ptr});
   endtask

   // Main sequence
   initial begin
      logic s;
      int   kind;
      int   pick;
      int   n;
      logic [7:0] a;

      clk_wait(5);
      @(negedge clk);
      check("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
      check("rst_reg_addr", {8'd0, reg_addr}, 16'd0);
      check("rst_update_value", {10'd0, update_value}, 16'd0);
      check("rst_strobe", {15'd0, read_or_write}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);
      rst_n = 1'b1;
      ena   = 1'b1;
      clk_wait(8);

      // 1: K_p write
      bus_start();
      dq.delete(); dq.push_back(8'h20); dq.push_back(8'h08);
      wr_body(8'h90);
      @(negedge clk);
      check("t1_busy", {15'd0, busy}, 16'd1);
      end_txn();
      check("t1_kp", {10'd0, rf[0]}, 16'd8);

      // 2: K_i, K_d burst
      bus_start();
      dq.delete(); dq.push_back(8'h21); dq.push_back(8'h10); dq.push_back(8'h20);
      wr_body(8'h90);
      end_txn();
      check("t2_ki", {10'd0, rf[1]}, 16'd16);
      check("t2_kd", {10'd0, rf[2]}, 16'd32);
      check("t2_ptr", {8'd0, reg_addr}, 16'h0023);

      // 3: pointer write, Sr, read K_d
      bus_start();
      dq.delete(); dq.push_back(8'h22);
      wr_body(8'h90);
      bus_rstart();
      rd_body(1);
      @(negedge clk);
      check("t3_busy_before_stop", {15'd0, busy}, 16'd1);
      end_txn();

      // 4: foreign address, then a good transfer
      bus_start();
      dq.delete(); dq.push_back(8'h20); dq.push_back(8'h2A);
      wr_body(8'h92);
      @(negedge clk);
      check("t4_busy_nack", {15'd0, busy}, 16'd0);
      end_txn();
      bus_start();
      wr_body(8'h90);
      end_txn();

      // 5: pointer wrap
      bus_start();
      dq.delete(); dq.push_back(8'hFF); dq.push_back(8'hC5); dq.push_back(8'h01);
      wr_body(8'h90);
      end_txn();
      check("t5_wrap_ptr", {8'd0, reg_addr}, 16'h0001);

      // 6a: reset in the middle of a data byte
      bus_start();
      dq.delete(); dq.push_back(8'h20);
      wr_body(8'h90);
      for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
      rst_n = 1'b0;
      #1;
      check("t6_rst_sda_oe", {15'd0, sda_oe}, 16'd0);
      check("t6_rst_reg_addr", {8'd0, reg_addr}, 16'd0);
      check("t6_rst_busy", {15'd0, busy}, 16'd0);
      check("t6_rst_update_value", {10'd0, update_value}, 16'd0);
      m_ptr = 8'h00;
      clk_wait(3);
      rst_n = 1'b1;
      end_txn();

      // 6b: ena dropped during the pointer-byte ACK
      bus_start();
      dq.delete();
      wr_body(8'h90);
      for (int i = 7; i >= 0; i--) bus_bit(a_bit(8'h21, i), s);
      m_ptr    = 8'h21;
      sda_ctrl = 1'b1; clk_wait(8);
      scl_drv  = 1'b1; clk_wait(4);
      @(negedge clk);
      check("t6_ack_driven", {15'd0, sda_oe}, 16'd1);
      ena = 1'b0;
      clk_wait(2);
      @(negedge clk);
      check("t6_ena_release", {15'd0, sda_oe}, 16'd0);
      clk_wait(9);
      scl_drv = 1'b0; clk_wait(8);
      wr_byte(8'h15, 1'b1, "t6_disabled_ack");
      end_txn();
      ena = 1'b1;
      clk_wait(4);
      bus_start();
      dq.delete(); dq.push_back(8'h22); dq.push_back(8'h2A);
      wr_body(8'h90);
      dq.delete(); dq.push_back(8'h21);
      bus_rstart();
      wr_body(8'h90);
      bus_rstart();
      rd_body(2);
      end_txn();

      // Randomised transfers
      for (int t = 0; t < 16; t++) begin
         kind = $urandom_range(0, 3);
         pick = $urandom_range(0, 5);
         case (pick)
            0, 1, 2: a = 8'h20 + 8'(pick);
            3:       a = 8'hFF;
            4:       a = 8'hFE;
            default: a = 8'($urandom_range(0, 255));
         endcase
         n = $urandom_range(1, 2);
         dq.delete();
         dq.push_back(a);
         bus_start();
         if (kind <= 1) begin
            for (int i = 0; i < n; i++) dq.push_back(8'($urandom_range(0, 255)));
            wr_body(8'h90);
         end else if (kind == 2) begin
            wr_body(8'h90);
            bus_rstart();
            rd_body(n);
         end else begin
            a = 8'($urandom_range(0, 127));
            if (a[6:0] == TB_DEV) a = 8'h49;
            wr_body({a[6:0], 1'($urandom_range(0, 1))});
         end
         end_txn();
      end

      clk_wait(20);
      check("bus_queue_drained", 16'(exp_q.size()), 16'd0);
      check("strobe_queue_drained", 16'(exp_stb_q.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   function automatic logic a_bit(input logic [7:0] v, input int i);
      return v[i];
   endfunction

endmodule
